// File: rtl/squant_ser.sv
// Accumulator-row quantiser/serialiser feeding the sbuf result write port.
// Optional macro SQUANT_RELU_EN adds a relu input that clamps negative results to zero.
module squant_ser #(
   parameter int LANES  = 4,
   parameter int LIDX_W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [LANES*32-1:0]   acc_in,
   input  logic                  acc_valid,
   input  logic [4:0]            shift,
   input  logic                  ovf_clr,
`ifdef SQUANT_RELU_EN
   input  logic                  relu,
`endif
   output logic                  busy,
   output logic [15:0]           s_out,
   output logic                  sat,
   output logic                  sw,
   output logic                  ovf
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   logic [0:0]        state_q;
   logic [LIDX_W-1:0] idx_q;
   logic [31:0]       lanes_q [LANES];
   logic [4:0]        shift_q;
   logic              relu_q;

   logic              last;
   logic              capture;
   logic              overrun;
   logic [31:0]       lane;
   logic signed [32:0] ext;
   logic signed [32:0] rnd;
   logic signed [32:0] sum;
   logic signed [32:0] res;
   logic [15:0]       q_val;
   logic              q_sat;

   assign last    = (idx_q == LIDX_W'(LANES - 1));
   assign capture = acc_valid && ((state_q == IDLE) || last);
   assign overrun = acc_valid && (state_q == RUN) && !last;
   assign busy    = (state_q == RUN);

`ifdef SQUANT_RELU_EN
   logic relu_in;
   assign relu_in = relu;
`else
   logic relu_in;
   assign relu_in = 1'b0;
`endif

   always_comb begin
      lane = '0;
      for (int i = 0; i < LANES; i++) begin
         if (idx_q == LIDX_W'(i)) lane = lanes_q[i];
      end
   end

   // Round half up, arithmetic shift, then clip into the signed 16-bit range.
   always_comb begin
      ext = {lane[31], lane};
      rnd = '0;
      if (shift_q != 5'd0) rnd = 33'sd1 <<< (shift_q - 5'd1);
      sum = ext + rnd;
      res = sum >>> shift_q;
      q_val = res[15:0];
      q_sat = 1'b0;
      if (res > 33'sd32767) begin
         q_val = 16'h7FFF;
         q_sat = 1'b1;
      end else if (relu_q && res[32]) begin
         q_val = 16'h0000;
      end else if (res < -33'sd32768) begin
         q_val = 16'h8000;
         q_sat = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         shift_q <= '0;
         relu_q  <= 1'b0;
         for (int i = 0; i < LANES; i++) lanes_q[i] <= '0;
         s_out   <= '0;
         sat     <= 1'b0;
         sw      <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         if (capture) begin
            for (int i = 0; i < LANES; i++) lanes_q[i] <= acc_in[32*i +: 32];
            shift_q <= shift;
            relu_q  <= relu_in;
            idx_q   <= '0;
            state_q <= RUN;
         end else if (state_q == RUN) begin
            if (last) begin
               state_q <= IDLE;
               idx_q   <= '0;
            end else begin
               idx_q <= idx_q + 1'b1;
            end
         end

         if (overrun) ovf <= 1'b1;
         else if (ovf_clr) ovf <= 1'b0;

         // Output registers only move while a lane is being emitted.
         sw <= (state_q == RUN);
         if (state_q == RUN) begin
            s_out <= q_val;
            sat   <= q_sat;
         end
      end
   end

endmodule
